// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory responder slice: address/data widths,
// the responder FSM state encoding, the captured operation encoding and a
// helper that turns the two request levels into an operation.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    // FSM states of the responder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation latched at the capture edge
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ERR   = 2'd2
    } op_t;

    // Both request levels high at once is an illegal request and is
    // answered with an error instead of touching memory.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr)
            return OP_ERR;
        else if (wr)
            return OP_WRITE;
        else
            return OP_READ;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array
// DEPTH x DATA_W word storage with one synchronous write port and two
// asynchronous read ports (one for the responder access path, one for the
// debug/display path). Contents are never reset.
// Ports:
//   clk       - write clock
//   we        - write enable, sampled on rising edge of clk
//   waddr     - write word address
//   wdata     - write data
//   raddr     - access read address, rdata is its combinational word
//   dbg_addr  - debug read address, dbg_data is its combinational word
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single synchronous write port; the storage itself has no reset so
    // an aborted transaction or a reset leaves the contents intact.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Four-phase request/acknowledge memory responder. A request seen in IDLE
// is captured, WAIT_CYCLES wait states are inserted, the access is done on
// the last WAIT edge and the responder then holds RESP (rsp_ready=1) until
// both request levels drop.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   req_read, req_write   - request levels from the initiator
//   req_addr, req_wdata   - word address and write data
//   rsp_rdata             - registered read data (held across writes/errors)
//   rsp_ready             - transaction complete (state == RESP)
//   rsp_err               - request rejected, valid while rsp_ready=1
//   busy                  - responder is not IDLE
//   dbg_addr, dbg_data    - combinational debug read port
//   access_count          - completed non-error accesses, saturating
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_ready,
    output logic              rsp_err,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       access_count
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    op_t               cap_op;
    logic [15:0]       access_count_q;
    logic              req_any;
    logic              access_edge;
    logic              mem_we;
    logic [DATA_W-1:0] arr_rdata;

    assign req_any     = req_read | req_write;
    assign access_edge = (state == WAIT) && (cnt == 4'd0);
    assign mem_we      = access_edge && (cap_op == OP_WRITE);

    mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (cap_addr),
        .wdata    (cap_wdata),
        .raddr    (cap_addr),
        .rdata    (arr_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. RESP is left only once the initiator has dropped
    // both request levels, which completes the four-phase handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_any)      next_state = WAIT;
            WAIT: if (cnt == 4'd0)  next_state = RESP;
            RESP: if (!req_any)     next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Request capture and wait-state counter. Inputs are only looked at in
    // IDLE, so the captured address/data/op stay fixed for the whole
    // transaction regardless of what the initiator does meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_op    <= OP_READ;
        end else if (state == IDLE && req_any) begin
            cnt       <= WAIT_LOAD;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_op    <= decode_op(req_read, req_write);
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers. On the access edge a read loads rsp_rdata, an
    // error raises rsp_err, and every non-error access bumps the
    // saturating counter. rsp_rdata is untouched by writes and errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            access_count_q <= 16'd0;
        end else if (access_edge) begin
            if (cap_op == OP_READ)
                rsp_rdata <= arr_rdata;
            rsp_err <= (cap_op == OP_ERR);
            if (cap_op != OP_ERR && access_count_q != 16'hFFFF)
                access_count_q <= access_count_q + 16'd1;
        end else if (state == RESP && next_state == IDLE) begin
            rsp_err <= 1'b0;
        end
    end

    assign rsp_ready    = (state == RESP);
    assign busy         = (state != IDLE);
    assign access_count = access_count_q;

endmodule
